// File: rtl/ysyx_041461_hazard_scoreboard_if.sv
// ID/WB/trap-side bundle for the register hazard scoreboard.
//   master : the pipeline side (ID issue request, WB retire, trap flush); samples issue_ready.
//   slave  : the scoreboard; returns issue_ready.
// Signals:
//   issue_valid, issue_ready, issue_rd_we, issue_rd[AW], issue_rs_en[NRP], issue_rs[NRP*AW]
//   wb_valid, wb_rd[AW], flush
interface ysyx_041461_hazard_scoreboard_if #(
  parameter int unsigned AW  = 5,
  parameter int unsigned NRP = 2
) ();
  logic                issue_valid;
  logic                issue_ready;
  logic                issue_rd_we;
  logic [AW-1:0]       issue_rd;
  logic [NRP-1:0]      issue_rs_en;
  logic [NRP*AW-1:0]   issue_rs;
  logic                wb_valid;
  logic [AW-1:0]       wb_rd;
  logic                flush;

  modport master (
    output issue_valid, issue_rd_we, issue_rd, issue_rs_en, issue_rs, wb_valid, wb_rd, flush,
    input  issue_ready
  );

  modport slave (
    input  issue_valid, issue_rd_we, issue_rd, issue_rs_en, issue_rs, wb_valid, wb_rd, flush,
    output issue_ready
  );
endinterface

// File: rtl/ysyx_041461_hazard_scoreboard.sv
// Register scoreboard for the ID stage. Each GPR (except x0) has a pending-write counter that
// is bumped when a writer issues and decremented when it retires, so the RAW check is
// independent of pipeline depth.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   sb (slave)     issue request/ready, WB retire, trap flush
//   busy           bit r set while register r has a pending write
//   stall_cycles   saturating count of cycles where ID wanted to issue but was held
//   err_underflow  sticky: a retire arrived for a register with no pending write
// Optional build macro: YSYX_041461_SB_WB_BYPASS_EN -- a retire that drops the last pending
// write of a source register clears the RAW hazard in the same cycle (ID takes the operand
// from the WB bypass). Undefined: the dependent issues one cycle after the retire.
module ysyx_041461_hazard_scoreboard #(
  parameter int unsigned NREG    = 32,
  parameter int unsigned AW      = 5,
  parameter int unsigned NRP     = 2,
  parameter int unsigned CNT_W   = 2,
  parameter int unsigned STALL_W = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  ysyx_041461_hazard_scoreboard_if.slave    sb,
  output logic [NREG-1:0]                   busy,
  output logic [STALL_W-1:0]                stall_cycles,
  output logic                              err_underflow
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [CNT_W-1:0]   cnt_q [NREG];
  logic [CNT_W-1:0]   cnt_d [NREG];
  logic [NREG-1:0]    busy_vec;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               err_q, err_d;

  logic raw_hazard;
  logic sat_hazard;
  logic fire;
  logic wr_en;
  logic rt_en;
  logic underflow;
  logic stall_inc;

  // x0 never accumulates a count because wr_en/rt_en exclude index 0.
  always_comb begin
    busy_vec = '0;
    for (int r = 1; r < int'(NREG); r++) begin
      busy_vec[r] = (cnt_q[r] != '0);
    end
  end

  always_comb begin
    logic [AW-1:0] rs_idx;
    rs_idx     = '0;
    raw_hazard = 1'b0;
    for (int i = 0; i < int'(NRP); i++) begin
      rs_idx = sb.issue_rs[i*AW +: AW];
      if (sb.issue_rs_en[i] && (rs_idx != '0) && busy_vec[rs_idx]) begin
`ifdef YSYX_041461_SB_WB_BYPASS_EN
        // Last outstanding writer retiring now: operand is available on the WB bypass.
        if (!(sb.wb_valid && (sb.wb_rd == rs_idx) && (cnt_q[rs_idx] == CntOne))) begin
          raw_hazard = 1'b1;
        end
`else
        raw_hazard = 1'b1;
`endif
      end
    end
  end

  // Counter would wrap on another writer to the same rd.
  assign sat_hazard = sb.issue_rd_we && (sb.issue_rd != '0) && (cnt_q[sb.issue_rd] == CntMax);

  assign sb.issue_ready = !sb.flush && !raw_hazard && !sat_hazard;
  assign fire           = sb.issue_valid && sb.issue_ready;

  assign wr_en     = fire && sb.issue_rd_we && (sb.issue_rd != '0);
  assign rt_en     = sb.wb_valid && (sb.wb_rd != '0) && busy_vec[sb.wb_rd];
  assign underflow = sb.wb_valid && (sb.wb_rd != '0) && !busy_vec[sb.wb_rd];
  assign stall_inc = sb.issue_valid && !sb.issue_ready && !sb.flush;

  always_comb begin
    logic inc;
    logic dec;
    inc = 1'b0;
    dec = 1'b0;
    for (int r = 0; r < int'(NREG); r++) begin
      inc      = wr_en && (sb.issue_rd == AW'(r));
      dec      = rt_en && (sb.wb_rd == AW'(r));
      cnt_d[r] = cnt_q[r];
      if (sb.flush) begin
        // Flush only arrives once older writers have drained, so clearing is exact.
        cnt_d[r] = '0;
      end else if (inc && !dec) begin
        cnt_d[r] = cnt_q[r] + CntOne;
      end else if (dec && !inc) begin
        cnt_d[r] = cnt_q[r] - CntOne;
      end
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (stall_inc && (stall_q != '1)) begin
      stall_d = stall_q + STALL_W'(1);
    end
    err_d = err_q || underflow;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < int'(NREG); r++) begin
        cnt_q[r] <= '0;
      end
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      for (int r = 0; r < int'(NREG); r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  assign busy          = busy_vec;
  assign stall_cycles  = stall_q;
  assign err_underflow = err_q;

endmodule
